// File: rtl/scs8hd_lpflow_lsbuf_hl_xfer.sv
// High-to-low domain word transmitter.
// Releases isolation once the low rail is reported good and settled, then moves
// each word across with a 4-phase req/ack handshake. Power loss or a stalled
// handshake drops back to the clamped (isolated) state.
module scs8hd_lpflow_lsbuf_hl_xfer #(
    parameter int WIDTH       = 8,
    parameter int SETTLE_CYC  = 4,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             lowpwr_good,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ls_req,
    output logic [WIDTH-1:0] ls_data,
    input  logic             ls_ack,
    output logic             iso_en,
    output logic             busy,
    output logic             err_timeout,
    output logic             err_drop
);

    // One counter serves both the settle delay and the handshake timeout, so it
    // is sized for whichever of the two needs more bits.
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int CW = (TW > SW) ? TW : SW;

    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] TO_LAST     = CW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_ISO,
        ST_SETTLE,
        ST_IDLE,
        ST_REQ,
        ST_REL
    } state_t;

    logic             pg_meta_q, pg_s_q;
    logic             ack_meta_q, ack_s_q;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             iso_q, ready_q, req_q, busy_q, to_q, drop_q;
    logic             to_d, drop_d;

    // Two-flop synchronizers for the asynchronous rail-good and ack inputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pg_meta_q  <= 1'b0;
            pg_s_q     <= 1'b0;
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
        end else begin
            pg_meta_q  <= lowpwr_good;
            pg_s_q     <= pg_meta_q;
            ack_meta_q <= ls_ack;
            ack_s_q    <= ack_meta_q;
        end
    end

    // Next-state logic; power loss outranks everything, including a timeout.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        to_d    = 1'b0;
        drop_d  = 1'b0;
        if (!pg_s_q && (state_q != ST_ISO)) begin
            state_d = ST_ISO;
            data_d  = '0;
            drop_d  = (state_q == ST_REQ) || (state_q == ST_REL);
        end else begin
            case (state_q)
                ST_ISO: begin
                    data_d = '0;
                    if (pg_s_q) begin
                        state_d = ST_SETTLE;
                        cnt_d   = SETTLE_LOAD;
                    end
                end
                ST_SETTLE: begin
                    // A stale ack from before isolation must clear before opening up.
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (!ack_s_q) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (in_valid && ready_q) begin
                        data_d  = in_data;
                        state_d = ST_REQ;
                        cnt_d   = '0;
                    end
                end
                ST_REQ: begin
                    if (ack_s_q) begin
                        state_d = ST_REL;
                        cnt_d   = '0;
                    end else if (cnt_q == TO_LAST) begin
                        state_d = ST_ISO;
                        data_d  = '0;
                        to_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_REL: begin
                    if (!ack_s_q) begin
                        state_d = ST_IDLE;
                    end else if (cnt_q == TO_LAST) begin
                        state_d = ST_ISO;
                        data_d  = '0;
                        to_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_ISO;
                    data_d  = '0;
                end
            endcase
        end
    end

    // State register with outputs decoded from the next state so they are glitch-free flops.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_ISO;
            cnt_q   <= '0;
            data_q  <= '0;
            iso_q   <= 1'b1;
            ready_q <= 1'b0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            to_q    <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            iso_q   <= (state_d == ST_ISO) || (state_d == ST_SETTLE);
            ready_q <= (state_d == ST_IDLE);
            req_q   <= (state_d == ST_REQ);
            busy_q  <= (state_d == ST_REQ) || (state_d == ST_REL);
            to_q    <= to_d;
            drop_q  <= drop_d;
        end
    end

    assign in_ready    = ready_q;
    assign ls_req      = req_q;
    assign ls_data     = data_q;
    assign iso_en      = iso_q;
    assign busy        = busy_q;
    assign err_timeout = to_q;
    assign err_drop    = drop_q;

endmodule

// File: tb/tb_scs8hd_lpflow_lsbuf_hl_xfer.sv
// Directed bench for the high-to-low word transmitter.
// Output flags are checked as one vector {iso_en, in_ready, ls_req, busy, err_timeout, err_drop}.
module tb_scs8hd_lpflow_lsbuf_hl_xfer;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       lowpwr_good;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       ls_req;
    logic [7:0] ls_data;
    logic       ls_ack;
    logic       iso_en;
    logic       busy;
    logic       err_timeout;
    logic       err_drop;

    int checks = 0;
    int errors = 0;

    logic [5:0] obs;
    assign obs = {iso_en, in_ready, ls_req, busy, err_timeout, err_drop};

    scs8hd_lpflow_lsbuf_hl_xfer #(
        .WIDTH(8),
        .SETTLE_CYC(4),
        .ACK_TIMEOUT(15)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .lowpwr_good(lowpwr_good),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .ls_req(ls_req),
        .ls_data(ls_data),
        .ls_ack(ls_ack),
        .iso_en(iso_en),
        .busy(busy),
        .err_timeout(err_timeout),
        .err_drop(err_drop)
    );

    always #5 CLK = ~CLK;

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] exp;
        RESET       = 1'b1;
        lowpwr_good = 1'b1;
        in_valid    = 1'b0;
        ls_ack      = 1'b0;
        in_data     = 8'h00;
        repeat (3) step();
        checks++;
        if (obs !== 6'b100000 || ls_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_hold: flags got %b expected 100000, data got %h expected 00", obs, ls_data);
        end
        RESET = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            exp = (k < 7) ? 6'b100000 : 6'b010000;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_release step %0d: flags got %b expected %b", k, obs, exp);
            end
        end
        $display("reset released, isolation opened after settle");
    endtask

    task automatic test_single();
        logic [5:0] exp;
        in_data  = 8'hA5;
        in_valid = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            step();
            if (k == 0) in_valid = 1'b0;
            exp = {1'b0, (k == 12), (k <= 5), (k <= 11), 1'b0, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL single_flags step %0d: got %b expected %b", k, obs, exp);
            end
            if (k < 12) begin
                checks++;
                if (ls_data !== 8'hA5) begin
                    errors++;
                    $display("FAIL single_data step %0d: got %h expected a5", k, ls_data);
                end
            end
            if (k == 3) ls_ack = 1'b1;
            if (k == 9) ls_ack = 1'b0;
        end
        $display("xfer word a5 complete");
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp;
        logic [7:0] words [3];
        words[0] = 8'h01;
        words[1] = 8'h02;
        words[2] = 8'h03;
        in_valid = 1'b1;
        for (int w = 0; w < 3; w++) begin
            in_data = words[w];
            for (int k = 0; k <= 12; k++) begin
                step();
                // Upstream changes its bus mid-transfer; the held word must not follow.
                if (k == 1) in_data = ~words[w];
                exp = {1'b0, (k == 12), (k <= 5), (k <= 11), 1'b0, 1'b0};
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL b2b_flags word %0d step %0d: got %b expected %b", w, k, obs, exp);
                end
                if (k < 12) begin
                    checks++;
                    if (ls_data !== words[w]) begin
                        errors++;
                        $display("FAIL b2b_data word %0d step %0d: got %h expected %h", w, k, ls_data, words[w]);
                    end
                end
                if (k == 3) ls_ack = 1'b1;
                if (k == 9) ls_ack = 1'b0;
            end
            $display("xfer word %h complete (back to back)", words[w]);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_timeout();
        logic [5:0] exp;
        logic [7:0] exp_data;
        in_data  = 8'h3C;
        in_valid = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            step();
            if (k == 0) in_valid = 1'b0;
            exp = {(k >= 15 && k <= 19), (k == 20), (k <= 14), (k <= 14), (k == 15), 1'b0};
            exp_data = (k <= 14) ? 8'h3C : 8'h00;
            checks++;
            if (obs !== exp || ls_data !== exp_data) begin
                errors++;
                $display("FAIL timeout step %0d: flags got %b expected %b, data got %h expected %h",
                         k, obs, exp, ls_data, exp_data);
            end
        end
        $display("xfer word 3c aborted by timeout, settle re-run");
    endtask

    task automatic test_power_loss();
        logic [5:0] exp;
        logic [7:0] exp_data;
        in_data  = 8'h5A;
        in_valid = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            step();
            if (k == 0) in_valid = 1'b0;
            if (k <= 3)       exp = 6'b001100;
            else if (k == 4)  exp = 6'b100001;
            else              exp = 6'b100000;
            exp_data = (k <= 3) ? 8'h5A : 8'h00;
            checks++;
            if (obs !== exp || ls_data !== exp_data) begin
                errors++;
                $display("FAIL power_loss step %0d: flags got %b expected %b, data got %h expected %h",
                         k, obs, exp, ls_data, exp_data);
            end
            if (k == 1) lowpwr_good = 1'b0;
        end
        $display("xfer word 5a dropped by power loss");
        lowpwr_good = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            exp = (k < 7) ? 6'b100000 : 6'b010000;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL power_return step %0d: got %b expected %b", k, obs, exp);
            end
        end
        $display("low rail restored, isolation reopened");
    endtask

    task automatic test_reset_mid_rel();
        logic [5:0] exp;
        in_data  = 8'h77;
        in_valid = 1'b1;
        for (int k = 0; k <= 7; k++) begin
            step();
            if (k == 0) in_valid = 1'b0;
            exp = (k <= 5) ? 6'b001100 : 6'b000100;
            checks++;
            if (obs !== exp || ls_data !== 8'h77) begin
                errors++;
                $display("FAIL pre_reset step %0d: flags got %b expected %b, data got %h expected 77",
                         k, obs, exp, ls_data);
            end
            if (k == 3) ls_ack = 1'b1;
        end
        // Assert reset between clock edges: outputs must clear without a clock.
        #2;
        RESET = 1'b1;
        #1;
        checks++;
        if (obs !== 6'b100000 || ls_data !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: flags got %b expected 100000, data got %h expected 00", obs, ls_data);
        end
        step();
        step();
        RESET = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            step();
            exp = (k < 13) ? 6'b100000 : 6'b010000;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL stale_ack step %0d: got %b expected %b", k, obs, exp);
            end
            if (k == 10) ls_ack = 1'b0;
        end
        $display("reset during release phase, stale ack held settle until cleared");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_power_loss();
        test_reset_mid_rel();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
